// File: rtl/sram_arb_pkg.sv
// Shared types for the two-master SRAM request arbiter: FSM states, owner id, size codes.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef logic owner_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/sram_req_arbiter_rr_arb2.sv
// Two-way round-robin picker: combinational grant from req + last_grant pointer,
// pointer advances only when the grant is actually taken.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic [1:0] o_grant,
  output owner_t     o_grant_idx
);

  owner_t r_last_grant;
  owner_t w_pick;

  // On a conflict the master that did not win last time goes first.
  always_comb begin
    w_pick = 1'b0;
    if (i_req == 2'b11) begin
      w_pick = ~r_last_grant;
    end else if (i_req[1]) begin
      w_pick = 1'b1;
    end
  end

  assign o_grant     = i_req & (w_pick ? 2'b10 : 2'b01);
  assign o_grant_idx = w_pick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (i_take && (|i_req)) begin
      r_last_grant <= w_pick;
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Round-robin arbiter putting instruction fetch (m0) and load/store (m1) onto one SRAM port,
// one transaction in flight. Optional SRAM_ARB_PERF_EN adds grant/conflict counters.
module sram_req_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [MASK_WIDTH-1:0] m0_wmask,
  input  logic [1:0]            m0_size,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ready,
  output logic                  m0_resp_valid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [MASK_WIDTH-1:0] m1_wmask,
  input  logic [1:0]            m1_size,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ready,
  output logic                  m1_resp_valid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  data_req,
  output logic [ADDR_WIDTH-1:0] data_addr,
  output logic [MASK_WIDTH-1:0] data_wmask,
  output logic [1:0]            data_size,
  output logic [DATA_WIDTH-1:0] data_wdata,
  input  logic [DATA_WIDTH-1:0] data_rdata,
  input  logic                  data_stall,
  input  logic                  data_valid
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_grant0,
  output logic [31:0]           perf_grant1,
  output logic [31:0]           perf_conflict
`endif
);

  state_t                r_state;
  owner_t                r_owner;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [MASK_WIDTH-1:0] r_wmask;
  logic [1:0]            r_size;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic [1:0]            w_req;
  logic [1:0]            w_grant;
  owner_t                w_grant_idx;
  logic                  w_idle;
  logic                  w_accept;
  logic                  w_issue;
  logic                  w_resp;
  logic [DATA_WIDTH-1:0] w_resp_data;
  logic [1:0]            w_resp_valid;
  logic [DATA_WIDTH-1:0] w_rdata_arr [2];

  assign w_req    = {m1_req, m0_req};
  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle && (|w_req);

  rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .rst_n       (rst),
    .i_req       (w_req),
    .i_take      (w_idle),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  // Gating with rst keeps ready low while reset is held, even though state already reads IDLE.
  assign m0_ready = rst && w_idle && w_grant[0];
  assign m1_ready = rst && w_idle && w_grant[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_addr  <= '0;
      r_wmask <= '0;
      r_size  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner <= w_grant_idx;
            r_addr  <= w_grant_idx ? m1_addr  : m0_addr;
            r_wmask <= w_grant_idx ? m1_wmask : m0_wmask;
            r_size  <= w_grant_idx ? m1_size  : m0_size;
            r_wdata <= w_grant_idx ? m1_wdata : m0_wdata;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!data_stall) begin
            r_state <= RESP;
          end
        end
        RESP: begin
          if (data_valid) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_issue    = (r_state == ISSUE);
  assign data_req   = w_issue;
  assign data_addr  = w_issue ? r_addr  : '0;
  assign data_wmask = w_issue ? r_wmask : '0;
  assign data_size  = w_issue ? r_size  : '0;
  assign data_wdata = w_issue ? r_wdata : '0;

  // Writes (non-zero mask) return zero data rather than whatever the SRAM drives.
  assign w_resp      = (r_state == RESP) && data_valid;
  assign w_resp_data = (r_wmask == '0) ? data_rdata : '0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign w_resp_valid[gi] = w_resp && (r_owner == owner_t'(gi));
    assign w_rdata_arr[gi]  = w_resp_valid[gi] ? w_resp_data : '0;
  end

  assign m0_resp_valid = w_resp_valid[0];
  assign m1_resp_valid = w_resp_valid[1];
  assign m0_rdata      = w_rdata_arr[0];
  assign m1_rdata      = w_rdata_arr[1];

`ifdef SRAM_ARB_PERF_EN
  logic [31:0] r_perf_grant0;
  logic [31:0] r_perf_grant1;
  logic [31:0] r_perf_conflict;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_grant0   <= '0;
      r_perf_grant1   <= '0;
      r_perf_conflict <= '0;
    end else begin
      if (w_accept && !w_grant_idx) begin
        r_perf_grant0 <= r_perf_grant0 + 32'd1;
      end
      if (w_accept && w_grant_idx) begin
        r_perf_grant1 <= r_perf_grant1 + 32'd1;
      end
      if (w_idle && (&w_req)) begin
        r_perf_conflict <= r_perf_conflict + 32'd1;
      end
    end
  end

  assign perf_grant0   = r_perf_grant0;
  assign perf_grant1   = r_perf_grant1;
  assign perf_conflict = r_perf_conflict;
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Table-driven bench for sram_req_arbiter with a small SRAM model and a response scoreboard.
// Build with SRAM_ARB_PERF_EN defined to also check the performance counters.
module tb_sram_req_arbiter;
  import sram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr;
  logic [4:0]  m0_wmask, m1_wmask;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ready, m1_ready;
  logic        m0_resp_valid, m1_resp_valid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        data_req;
  logic [31:0] data_addr;
  logic [4:0]  data_wmask;
  logic [1:0]  data_size;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_stall;
  logic        data_valid;
`ifdef SRAM_ARB_PERF_EN
  logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

  logic [31:0] sram_val;
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        req0;
    logic        req1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [4:0]  wm0;
    logic [4:0]  wm1;
    logic [1:0]  sz0;
    logic [1:0]  sz1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic [31:0] sram;
    logic        owner;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        owner;
    logic [31:0] rdata;
  } exp_t;

  vec_t tbl [8];
  exp_t sb_q[$];

  always #5 clk = ~clk;

  sram_req_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .m0_req        (m0_req),
    .m0_addr       (m0_addr),
    .m0_wmask      (m0_wmask),
    .m0_size       (m0_size),
    .m0_wdata      (m0_wdata),
    .m0_ready      (m0_ready),
    .m0_resp_valid (m0_resp_valid),
    .m0_rdata      (m0_rdata),
    .m1_req        (m1_req),
    .m1_addr       (m1_addr),
    .m1_wmask      (m1_wmask),
    .m1_size       (m1_size),
    .m1_wdata      (m1_wdata),
    .m1_ready      (m1_ready),
    .m1_resp_valid (m1_resp_valid),
    .m1_rdata      (m1_rdata),
    .data_req      (data_req),
    .data_addr     (data_addr),
    .data_wmask    (data_wmask),
    .data_size     (data_size),
    .data_wdata    (data_wdata),
    .data_rdata    (data_rdata),
    .data_stall    (data_stall),
    .data_valid    (data_valid)
`ifdef SRAM_ARB_PERF_EN
    ,
    .perf_grant0   (perf_grant0),
    .perf_grant1   (perf_grant1),
    .perf_conflict (perf_conflict)
`endif
  );

  // SRAM model: read data registered one cycle after an unstalled request.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_valid <= 1'b0;
      data_rdata <= '0;
    end else begin
      data_valid <= data_req && !data_stall;
      data_rdata <= (data_req && !data_stall) ? sram_val : 32'h0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {53'd0, data_req, m0_ready, m1_ready, m0_resp_valid, m1_resp_valid,
               |data_addr, |data_wmask, |data_size, |data_wdata, |m0_rdata, |m1_rdata}, 64'd0);
  endtask

  // Scoreboard: every response pulse must match the oldest accepted request.
  always @(negedge clk) begin
    if (rst && (m0_resp_valid || m1_resp_valid)) begin
      exp_t e;
      if (m0_resp_valid && m1_resp_valid) begin
        chk("resp_both", 64'd1, 64'd0);
      end else if (sb_q.size() == 0) begin
        chk("resp_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("resp_owner", {63'd0, m1_resp_valid}, {63'd0, e.owner});
        chk("resp_rdata", m1_resp_valid ? m1_rdata : m0_rdata, e.rdata);
        $display("resp m%0d rdata=%08h", m1_resp_valid ? 1 : 0, m1_resp_valid ? m1_rdata : m0_rdata);
      end
    end
  end

  // Drives one request vector and follows it through accept, issue (with k stall cycles) and response.
  task automatic run_vec(input vec_t v, input int k);
    bit          got;
    exp_t        e;
    logic [31:0] ea;
    logic [4:0]  ew;
    logic [1:0]  es;
    logic [31:0] ed;
    @(posedge clk); #1;
    m0_req = v.req0; m0_addr = v.addr0; m0_wmask = v.wm0; m0_size = v.sz0; m0_wdata = v.wd0;
    m1_req = v.req1; m1_addr = v.addr1; m1_wmask = v.wm1; m1_size = v.sz1; m1_wdata = v.wd1;
    sram_val   = v.sram;
    data_stall = (k > 0);
    got = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (m0_ready || m1_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("accept_timeout", 64'd0, 64'd1);
      m0_req = 1'b0; m1_req = 1'b0; data_stall = 1'b0;
      return;
    end
    chk("grant", {62'd0, m1_ready, m0_ready}, v.owner ? 64'd2 : 64'd1);
    e.owner = v.owner;
    e.rdata = v.exp_rdata;
    sb_q.push_back(e);
    ea = v.owner ? v.addr1 : v.addr0;
    ew = v.owner ? v.wm1   : v.wm0;
    es = v.owner ? v.sz1   : v.sz0;
    ed = v.owner ? v.wd1   : v.wd0;
    $display("txn m%0d addr=%08h wmask=%05b size=%0d wdata=%08h", v.owner, ea, ew, es, ed);
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0;
    for (int s = 1; s <= k + 1; s++) begin
      if (s == k + 1) data_stall = 1'b0;
      @(negedge clk);
      chk("issue_req",   {63'd0, data_req}, 64'd1);
      chk("issue_addr",  {32'd0, data_addr}, {32'd0, ea});
      chk("issue_wmask", {59'd0, data_wmask}, {59'd0, ew});
      chk("issue_size",  {62'd0, data_size}, {62'd0, es});
      chk("issue_wdata", {32'd0, data_wdata}, {32'd0, ed});
      chk("issue_no_resp", {62'd0, m1_resp_valid, m0_resp_valid}, 64'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("resp_pulse", {62'd0, m1_resp_valid, m0_resp_valid}, v.owner ? 64'd2 : 64'd1);
    chk("resp_req_low", {63'd0, data_req}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t sv;
    rst = 1'b0;
    m0_req = 0; m0_addr = 0; m0_wmask = 0; m0_size = 0; m0_wdata = 0;
    m1_req = 0; m1_addr = 0; m1_wmask = 0; m1_size = 0; m1_wdata = 0;
    data_stall = 1'b0;
    sram_val = 32'h0;

    //        req0 req1 addr0         addr1         wm0    wm1    sz0     sz1     wd0           wd1           sram          own  rdata
    tbl[0] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,        5'h00, 5'h00, SIZE_W, SIZE_B, 32'h0,        32'h0,        32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
    tbl[1] = '{1'b0, 1'b1, 32'h0,         32'h100,      5'h00, 5'h0F, SIZE_B, SIZE_W, 32'h0,        32'h1234_5678, 32'hAAAA_5555, 1'b1, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 32'h10,        32'h20,       5'h00, 5'h00, SIZE_B, SIZE_H, 32'h0,        32'h0,        32'h0000_00A5, 1'b0, 32'h0000_00A5};
    tbl[3] = '{1'b1, 1'b1, 32'h14,        32'h24,       5'h00, 5'h00, SIZE_B, SIZE_H, 32'h0,        32'h0,        32'h1111_2222, 1'b1, 32'h1111_2222};
    tbl[4] = '{1'b1, 1'b1, 32'h30,        32'h34,       5'h1F, 5'h00, SIZE_W, SIZE_W, 32'hCAFE_F00D, 32'h0,        32'h3333_4444, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 1'b1, 32'h38,        32'h40,       5'h00, 5'h00, SIZE_W, SIZE_W, 32'h0,        32'h0,        32'h7777_8888, 1'b1, 32'h7777_8888};
    tbl[6] = '{1'b0, 1'b1, 32'h0,         32'hFFFF_FFFC, 5'h00, 5'h00, SIZE_B, SIZE_W, 32'h0,        32'h0,        32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF};
    tbl[7] = '{1'b1, 1'b0, 32'h3,         32'h0,        5'h01, 5'h00, SIZE_B, SIZE_B, 32'h0000_00EE, 32'h0,        32'h5A5A_5A5A, 1'b0, 32'h0};

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset_outs");
    m0_req = 1'b1; m1_req = 1'b1;
    #1;
    chk("reset_ready", {62'd0, m1_ready, m0_ready}, 64'd0);
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("idle_outs");

    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i], 0);
    end

    // m1 read held off by three stall cycles in ISSUE
    sv = '{1'b0, 1'b1, 32'h0, 32'h200, 5'h00, 5'h00, SIZE_B, SIZE_W, 32'h0, 32'h0, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D};
    run_vec(sv, 3);

    // Reset while m0's read sits in ISSUE: dropped, no response, pointer back to 1
    @(posedge clk); #1;
    m0_req = 1'b1; m0_addr = 32'h44; m0_wmask = 5'h0; m0_size = SIZE_W; m0_wdata = 32'h0;
    data_stall = 1'b1;
    @(negedge clk);
    chk("abort_accept", {62'd0, m1_ready, m0_ready}, 64'd1);
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b1; m1_addr = 32'h48;
    @(negedge clk);
    chk("abort_in_issue", {63'd0, data_req}, 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("abort_async_clear");
    @(posedge clk); #1;
    chk_all_zero("abort_held");
    rst = 1'b1; m1_req = 1'b0; data_stall = 1'b0;
    run_vec(tbl[2], 0);
    run_vec(tbl[6], 0);

    // Fresh reset, then three conflicts and three lone m0 requests
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    run_vec(tbl[2], 0);
    run_vec(tbl[3], 0);
    run_vec(tbl[4], 0);
    for (int i = 0; i < 3; i++) begin
      run_vec(tbl[0], 0);
    end
    repeat (2) @(negedge clk);
`ifdef SRAM_ARB_PERF_EN
    chk("perf_conflict", {32'd0, perf_conflict}, 64'd3);
    chk("perf_grant0",   {32'd0, perf_grant0}, 64'd5);
    chk("perf_grant1",   {32'd0, perf_grant1}, 64'd1);
`endif
    chk("queue_empty", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
